// File: rtl/mips_pkg.sv
// Shared MIPS-I encodings: major opcodes, R-type function codes and REGIMM selectors.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE  = 6'b000000,
        OP_REGIMM = 6'b000001,
        OP_BEQ    = 6'b000100,
        OP_BNE    = 6'b000101,
        OP_BLEZ   = 6'b000110,
        OP_BGTZ   = 6'b000111,
        OP_ADDIU  = 6'b001001,
        OP_SLTI   = 6'b001010,
        OP_SLTIU  = 6'b001011,
        OP_ANDI   = 6'b001100,
        OP_ORI    = 6'b001101,
        OP_XORI   = 6'b001110,
        OP_LUI    = 6'b001111,
        OP_LB     = 6'b100000,
        OP_LH     = 6'b100001,
        OP_LWL    = 6'b100010,
        OP_LW     = 6'b100011,
        OP_LBU    = 6'b100100,
        OP_LHU    = 6'b100101,
        OP_LWR    = 6'b100110,
        OP_SB     = 6'b101000,
        OP_SH     = 6'b101001,
        OP_SWL    = 6'b101010,
        OP_SW     = 6'b101011
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'b000000,
        F_SRL  = 6'b000010,
        F_SRA  = 6'b000011,
        F_SLLV = 6'b000100,
        F_SRLV = 6'b000110,
        F_SRAV = 6'b000111,
        F_ADDU = 6'b100001,
        F_SUBU = 6'b100011,
        F_AND  = 6'b100100,
        F_OR   = 6'b100101,
        F_XOR  = 6'b100110,
        F_NOR  = 6'b100111,
        F_SLT  = 6'b101010,
        F_SLTU = 6'b101011
    } alu_funct_t;

    localparam logic [4:0] RI_BLTZ   = 5'b00000;
    localparam logic [4:0] RI_BGEZ   = 5'b00001;
    localparam logic [4:0] RI_BLTZAL = 5'b10000;
    localparam logic [4:0] RI_BGEZAL = 5'b10001;

endpackage

// File: rtl/mips_gpr_file.sv
// 32x32 general-purpose register file: two combinational read ports, one
// synchronous write port, $0 hardwired to zero, synchronous reset clears all.
module mips_gpr_file
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_index,
    output logic [31:0] rs_data,
    input  logic [4:0]  rt_index,
    output logic [31:0] rt_data,
    input  logic [4:0]  wr_index,
    input  logic        wr_enable,
    input  logic [31:0] wr_data,
    output logic [31:0] register_v0
);

    logic [31:0] regs [32];

    // Reset wins over a coincident write; index 0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wr_enable && (wr_index != 5'd0)) begin
            regs[wr_index] <= wr_data;
        end
    end

    assign rs_data     = (rs_index == 5'd0) ? 32'h0 : regs[rs_index];
    assign rt_data     = (rt_index == 5'd0) ? 32'h0 : regs[rt_index];
    assign register_v0 = regs[2];

endmodule

// File: rtl/mips_alu_regfile.sv
// Execute/operand core: register file plus a combinational MIPS-I ALU whose
// operands are the two read ports.
module mips_alu_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_index,
    output logic [31:0] rs_data,
    input  logic [4:0]  rt_index,
    output logic [31:0] rt_data,
    input  logic [4:0]  wr_index,
    input  logic        wr_enable,
    input  logic [31:0] wr_data,
    output logic [31:0] register_v0,
    input  logic [5:0]  alu_opcode,
    input  logic [5:0]  alu_funct,
    input  logic [4:0]  alu_shamt,
    input  logic [15:0] alu_imm,
    input  logic [4:0]  alu_regimm,
    input  logic        alu_carry_in,
    output logic [31:0] alu_result,
    output logic        alu_branch,
    output logic        alu_carry_out,
    output logic        alu_zero,
    output logic        alu_link
);

    mips_gpr_file u_gpr (
        .clk         (clk),
        .reset       (reset),
        .rs_index    (rs_index),
        .rs_data     (rs_data),
        .rt_index    (rt_index),
        .rt_data     (rt_data),
        .wr_index    (wr_index),
        .wr_enable   (wr_enable),
        .wr_data     (wr_data),
        .register_v0 (register_v0)
    );

    logic [31:0] a, b, imm_se, imm_ze;
    logic [32:0] sum_ab, diff_ab, sum_ai;
    logic        unused_carry_in;

    // The CPU keeps a carry register, but no supported operation consumes it.
    assign unused_carry_in = alu_carry_in;

    assign a       = rs_data;
    assign b       = rt_data;
    assign imm_se  = {{16{alu_imm[15]}}, alu_imm};
    assign imm_ze  = {16'h0, alu_imm};
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff_ab = {1'b0, a} + {1'b0, ~b} + 33'd1;
    assign sum_ai  = {1'b0, a} + {1'b0, imm_se};

    always_comb begin
        alu_result    = 32'h0;
        alu_branch    = 1'b0;
        alu_carry_out = 1'b0;
        alu_link      = 1'b0;
        case (alu_opcode)
            OP_RTYPE: begin
                case (alu_funct)
                    F_ADDU: begin
                        alu_result    = sum_ab[31:0];
                        alu_carry_out = sum_ab[32];
                    end
                    F_SUBU: begin
                        alu_result    = diff_ab[31:0];
                        alu_carry_out = diff_ab[32];
                    end
                    F_AND:  alu_result = a & b;
                    F_OR:   alu_result = a | b;
                    F_XOR:  alu_result = a ^ b;
                    F_NOR:  alu_result = ~(a | b);
                    F_SLT:  alu_result = {31'h0, $signed(a) < $signed(b)};
                    F_SLTU: alu_result = {31'h0, a < b};
                    F_SLL:  alu_result = b << alu_shamt;
                    F_SRL:  alu_result = b >> alu_shamt;
                    F_SRA:  alu_result = $signed(b) >>> alu_shamt;
                    F_SLLV: alu_result = b << a[4:0];
                    F_SRLV: alu_result = b >> a[4:0];
                    F_SRAV: alu_result = $signed(b) >>> a[4:0];
                    default: alu_result = 32'h0;
                endcase
            end
            OP_ADDIU: begin
                alu_result    = sum_ai[31:0];
                alu_carry_out = sum_ai[32];
            end
            OP_SLTI:  alu_result = {31'h0, $signed(a) < $signed(imm_se)};
            OP_SLTIU: alu_result = {31'h0, a < imm_se};
            OP_ANDI:  alu_result = a & imm_ze;
            OP_ORI:   alu_result = a | imm_ze;
            OP_XORI:  alu_result = a ^ imm_ze;
            OP_LUI:   alu_result = {alu_imm, 16'h0};
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SWL, OP_SW: begin
                alu_result    = sum_ai[31:0];
                alu_carry_out = sum_ai[32];
            end
            OP_BEQ:  alu_branch = (a == b);
            OP_BNE:  alu_branch = (a != b);
            OP_BLEZ: alu_branch = a[31] || (a == 32'h0);
            OP_BGTZ: alu_branch = !a[31] && (a != 32'h0);
            OP_REGIMM: begin
                case (alu_regimm)
                    RI_BLTZ:   alu_branch = a[31];
                    RI_BGEZ:   alu_branch = !a[31];
                    RI_BLTZAL: begin
                        alu_branch = a[31];
                        alu_link   = 1'b1;
                    end
                    RI_BGEZAL: begin
                        alu_branch = !a[31];
                        alu_link   = 1'b1;
                    end
                    default: alu_branch = 1'b0;
                endcase
            end
            default: alu_result = 32'h0;
        endcase
    end

    assign alu_zero = (alu_result == 32'h0);

endmodule

// File: tb/tb_mips_alu_regfile.sv
// Directed self-checking bench for mips_alu_regfile: register file behaviour
// around reset and writes, then ALU/branch vectors with hand-computed results.
module tb_mips_alu_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_index, rt_index, wr_index;
    logic [31:0] rs_data, rt_data, wr_data, register_v0;
    logic        wr_enable;
    logic [5:0]  alu_opcode, alu_funct;
    logic [4:0]  alu_shamt, alu_regimm;
    logic [15:0] alu_imm;
    logic        alu_carry_in;
    logic [31:0] alu_result;
    logic        alu_branch, alu_carry_out, alu_zero, alu_link;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    mips_alu_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .rs_index      (rs_index),
        .rs_data       (rs_data),
        .rt_index      (rt_index),
        .rt_data       (rt_data),
        .wr_index      (wr_index),
        .wr_enable     (wr_enable),
        .wr_data       (wr_data),
        .register_v0   (register_v0),
        .alu_opcode    (alu_opcode),
        .alu_funct     (alu_funct),
        .alu_shamt     (alu_shamt),
        .alu_imm       (alu_imm),
        .alu_regimm    (alu_regimm),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_branch    (alu_branch),
        .alu_carry_out (alu_carry_out),
        .alu_zero      (alu_zero),
        .alu_link      (alu_link)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // driver tasks
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        wr_index  = idx;
        wr_data   = val;
        wr_enable = 1'b1;
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
    endtask

    task automatic set_alu(input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] sh, input logic [15:0] imm,
                           input logic [4:0] ri);
        write_reg(5'd8, a);
        write_reg(5'd9, b);
        rs_index   = 5'd8;
        rt_index   = 5'd9;
        alu_opcode = op;
        alu_funct  = fn;
        alu_shamt  = sh;
        alu_imm    = imm;
        alu_regimm = ri;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            rs_index = 5'(i);
            rt_index = 5'(31 - i);
            #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (rs_data !== exp_v || rt_data !== exp_v) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: rs=%h rt=%h expected %h", i, rs_data, rt_data, exp_v);
            end
        end
        n_cmp++;
        if (register_v0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_v0: got %h expected 00000000", register_v0);
        end
    endtask

    task automatic test_writes();
        write_reg(5'd0, 32'hDEADBEEF);
        rs_index = 5'd0;
        #1;
        n_cmp++;
        if (rs_data !== 32'h0) begin
            n_fail++;
            $display("FAIL write_r0: got %h expected 00000000", rs_data);
        end
        @(negedge clk);
        wr_index  = 5'd2;
        wr_data   = 32'h12345678;
        wr_enable = 1'b1;
        rs_index  = 5'd2;
        #1;
        n_cmp++;
        if (register_v0 !== 32'h0 || rs_data !== 32'h0) begin
            n_fail++;
            $display("FAIL v0_before_edge: v0=%h rs=%h expected 00000000", register_v0, rs_data);
        end
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
        n_cmp++;
        if (register_v0 !== 32'h12345678 || rs_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL v0_after_edge: v0=%h rs=%h expected 12345678", register_v0, rs_data);
        end
        @(negedge clk);
        reset     = 1'b1;
        wr_index  = 5'd2;
        wr_data   = 32'h55AA55AA;
        wr_enable = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        wr_enable = 1'b0;
        n_cmp++;
        if (register_v0 !== 32'h0 || rs_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vs_write: v0=%h rs=%h expected 00000000", register_v0, rs_data);
        end
    endtask

    task automatic test_arith();
        set_alu(32'hFFFFFFFF, 32'h1, 6'b000000, 6'b100001, 5'd0, 16'h0, 5'd0);
        n_cmp++;
        if (alu_result !== 32'h0 || alu_carry_out !== 1'b1 || alu_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL addu_wrap: res=%h c=%b z=%b expected 00000000 c=1 z=1", alu_result, alu_carry_out, alu_zero);
        end
        set_alu(32'd5, 32'd7, 6'b000000, 6'b100011, 5'd0, 16'h0, 5'd0);
        n_cmp++;
        if (alu_result !== 32'hFFFFFFFE || alu_carry_out !== 1'b0 || alu_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL subu_5_7: res=%h c=%b expected fffffffe c=0", alu_result, alu_carry_out);
        end
        set_alu(32'd7, 32'd5, 6'b000000, 6'b100011, 5'd0, 16'h0, 5'd0);
        n_cmp++;
        if (alu_result !== 32'h2 || alu_carry_out !== 1'b1) begin
            n_fail++;
            $display("FAIL subu_7_5: res=%h c=%b expected 00000002 c=1", alu_result, alu_carry_out);
        end
        set_alu(32'hFFFFFFFF, 32'h1, 6'b000000, 6'b101010, 5'd0, 16'h0, 5'd0);
        n_cmp++;
        if (alu_result !== 32'h1) begin
            n_fail++;
            $display("FAIL slt: got %h expected 00000001", alu_result);
        end
        alu_funct = 6'b101011;
        #1;
        n_cmp++;
        if (alu_result !== 32'h0 || alu_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sltu: got %h z=%b expected 00000000 z=1", alu_result, alu_zero);
        end
        set_alu(32'h0F0F00FF, 32'h00FF0F0F, 6'b000000, 6'b100111, 5'd0, 16'h0, 5'd0);
        n_cmp++;
        if (alu_result !== 32'hF000F000) begin
            n_fail++;
            $display("FAIL nor: got %h expected f000f000", alu_result);
        end
        alu_funct = 6'b100110;
        #1;
        n_cmp++;
        if (alu_result !== 32'h0FF00FF0) begin
            n_fail++;
            $display("FAIL xor: got %h expected 0ff00ff0", alu_result);
        end
        alu_funct = 6'b100000;
        #1;
        n_cmp++;
        if (alu_result !== 32'h0 || alu_zero !== 1'b1 || alu_carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL add_unsupported: got %h z=%b c=%b expected 0 z=1 c=0", alu_result, alu_zero, alu_carry_out);
        end
    endtask

    task automatic test_shifts();
        set_alu(32'h0, 32'h80000000, 6'b000000, 6'b000011, 5'd4, 16'h0, 5'd0);
        n_cmp++;
        if (alu_result !== 32'hF8000000) begin
            n_fail++;
            $display("FAIL sra: got %h expected f8000000", alu_result);
        end
        alu_funct = 6'b000010;
        #1;
        n_cmp++;
        if (alu_result !== 32'h08000000) begin
            n_fail++;
            $display("FAIL srl: got %h expected 08000000", alu_result);
        end
        set_alu(32'd36, 32'hF0F0F0F0, 6'b000000, 6'b000110, 5'd0, 16'h0, 5'd0);
        n_cmp++;
        if (alu_result !== 32'h0F0F0F0F) begin
            n_fail++;
            $display("FAIL srlv: got %h expected 0f0f0f0f", alu_result);
        end
        alu_funct = 6'b000100;
        #1;
        n_cmp++;
        if (alu_result !== 32'h0F0F0F00) begin
            n_fail++;
            $display("FAIL sllv: got %h expected 0f0f0f00", alu_result);
        end
    endtask

    task automatic test_immediates();
        set_alu(32'h0, 32'h0, 6'b001111, 6'b000000, 5'd0, 16'hABCD, 5'd0);
        n_cmp++;
        if (alu_result !== 32'hABCD0000) begin
            n_fail++;
            $display("FAIL lui: got %h expected abcd0000", alu_result);
        end
        set_alu(32'hFFFFFFFF, 32'h0, 6'b001100, 6'b000000, 5'd0, 16'h8001, 5'd0);
        n_cmp++;
        if (alu_result !== 32'h00008001) begin
            n_fail++;
            $display("FAIL andi: got %h expected 00008001", alu_result);
        end
        set_alu(32'h10, 32'h0, 6'b001001, 6'b000000, 5'd0, 16'hFFFF, 5'd0);
        n_cmp++;
        if (alu_result !== 32'h0000000F || alu_carry_out !== 1'b1) begin
            n_fail++;
            $display("FAIL addiu: got %h c=%b expected 0000000f c=1", alu_result, alu_carry_out);
        end
        alu_opcode = 6'b001011;
        #1;
        n_cmp++;
        if (alu_result !== 32'h1) begin
            n_fail++;
            $display("FAIL sltiu: got %h expected 00000001", alu_result);
        end
        set_alu(32'h1000, 32'h0, 6'b100011, 6'b000000, 5'd0, 16'hFFFC, 5'd0);
        n_cmp++;
        if (alu_result !== 32'h00000FFC || alu_branch !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_addr: got %h br=%b expected 00000ffc br=0", alu_result, alu_branch);
        end
        alu_opcode = 6'b000010;
        #1;
        n_cmp++;
        if (alu_result !== 32'h0 || alu_zero !== 1'b1 || alu_branch !== 1'b0 || alu_carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL other_opcode: got %h z=%b br=%b c=%b expected 0 z=1 br=0 c=0", alu_result, alu_zero, alu_branch, alu_carry_out);
        end
    endtask

    task automatic test_branches();
        set_alu(32'd7, 32'd7, 6'b000100, 6'b000000, 5'd0, 16'h0, 5'd0);
        n_cmp++;
        if (alu_branch !== 1'b1 || alu_result !== 32'h0) begin
            n_fail++;
            $display("FAIL beq: br=%b res=%h expected br=1 res=0", alu_branch, alu_result);
        end
        alu_opcode = 6'b000101;
        #1;
        n_cmp++;
        if (alu_branch !== 1'b0) begin
            n_fail++;
            $display("FAIL bne: br=%b expected 0", alu_branch);
        end
        set_alu(32'h0, 32'h0, 6'b000110, 6'b000000, 5'd0, 16'h0, 5'd0);
        n_cmp++;
        if (alu_branch !== 1'b1) begin
            n_fail++;
            $display("FAIL blez_zero: br=%b expected 1", alu_branch);
        end
        alu_opcode = 6'b000111;
        #1;
        n_cmp++;
        if (alu_branch !== 1'b0) begin
            n_fail++;
            $display("FAIL bgtz_zero: br=%b expected 0", alu_branch);
        end
        set_alu(32'hFFFFFFFF, 32'h0, 6'b000001, 6'b000000, 5'd0, 16'h0, 5'b10001);
        n_cmp++;
        if (alu_branch !== 1'b0 || alu_link !== 1'b1 || alu_result !== 32'h0) begin
            n_fail++;
            $display("FAIL bgezal_neg: br=%b link=%b res=%h expected br=0 link=1 res=0", alu_branch, alu_link, alu_result);
        end
        alu_regimm = 5'b10000;
        #1;
        n_cmp++;
        if (alu_branch !== 1'b1 || alu_link !== 1'b1) begin
            n_fail++;
            $display("FAIL bltzal_neg: br=%b link=%b expected br=1 link=1", alu_branch, alu_link);
        end
        set_alu(32'h80000000, 32'h0, 6'b000001, 6'b000000, 5'd0, 16'h0, 5'b00000);
        n_cmp++;
        if (alu_branch !== 1'b1 || alu_link !== 1'b0) begin
            n_fail++;
            $display("FAIL bltz_min: br=%b link=%b expected br=1 link=0", alu_branch, alu_link);
        end
        alu_regimm = 5'b00001;
        #1;
        n_cmp++;
        if (alu_branch !== 1'b0 || alu_link !== 1'b0) begin
            n_fail++;
            $display("FAIL bgez_min: br=%b link=%b expected br=0 link=0", alu_branch, alu_link);
        end
    endtask

    initial begin
        reset        = 1'b0;
        rs_index     = 5'd0;
        rt_index     = 5'd0;
        wr_index     = 5'd0;
        wr_data      = 32'h0;
        wr_enable    = 1'b0;
        alu_opcode   = 6'h0;
        alu_funct    = 6'h0;
        alu_shamt    = 5'd0;
        alu_imm      = 16'h0;
        alu_regimm   = 5'd0;
        alu_carry_in = 1'b0;
        test_reset();
        test_writes();
        test_arith();
        test_shifts();
        test_immediates();
        test_branches();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
